// File: rtl/wb_regfile.sv
// Writeback stage register file: selects the writeback value, commits it to
// the register array, serves two bypassed decode read ports and an unbypassed
// debug port, and counts retired writes (saturating).
module wb_regfile #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter bit          R0_ZERO    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_reg_write,
  input  logic                  wb_mem_to_reg,
  input  logic [DATA_WIDTH-1:0] wb_alu_result,
  input  logic [DATA_WIDTH-1:0] wb_read_data,
  input  logic [ADDR_WIDTH-1:0] wb_write_reg,
  input  logic [ADDR_WIDTH-1:0] rs_addr,
  input  logic [ADDR_WIDTH-1:0] rt_addr,
  output logic [DATA_WIDTH-1:0] rs_data,
  output logic [DATA_WIDTH-1:0] rt_data,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic [15:0]           retire_count
);

  localparam int unsigned NumRegs = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NumRegs];
  logic                  rs_is_zero;
  logic                  rt_is_zero;
  logic                  dbg_is_zero;

  // Writeback value select and effective-write qualification
  always_comb begin
    wb_data  = wb_mem_to_reg ? wb_read_data : wb_alu_result;
    wb_valid = wb_reg_write & ~(R0_ZERO & (wb_write_reg == '0));
  end

  // Register array commit; reset clears every entry and wins over a write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_valid) begin
      // An X on wb_reg_write evaluates false here, so storage is left intact
      regs[wb_write_reg] <= wb_data;
    end
  end

  // Decode read ports: hardwired zero, then same-cycle bypass, then storage
  always_comb begin
    rs_is_zero = R0_ZERO && (rs_addr == '0);
    rt_is_zero = R0_ZERO && (rt_addr == '0);

    if (rs_is_zero) begin
      rs_data = '0;
    end else if (wb_valid && (rs_addr == wb_write_reg)) begin
      rs_data = wb_data;
    end else begin
      rs_data = regs[rs_addr];
    end

    if (rt_is_zero) begin
      rt_data = '0;
    end else if (wb_valid && (rt_addr == wb_write_reg)) begin
      rt_data = wb_data;
    end else begin
      rt_data = regs[rt_addr];
    end
  end

  // Debug port shows committed state only
  always_comb begin
    dbg_is_zero = R0_ZERO && (dbg_addr == '0);
    dbg_data    = dbg_is_zero ? '0 : regs[dbg_addr];
  end

  // Retired-write counter; suppressed r0 writes still count, bubbles do not
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_count <= '0;
    end else if (wb_reg_write && (retire_count != 16'hFFFF)) begin
      retire_count <= retire_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expected output values for
// the current cycle, a monitor drains the queue at each falling edge.
module tb_wb_regfile;

  localparam int SigWbData  = 0;
  localparam int SigWbValid = 1;
  localparam int SigRs      = 2;
  localparam int SigRt      = 3;
  localparam int SigDbg     = 4;
  localparam int SigCount   = 5;

  typedef struct {
    string       name;
    int          sig;
    logic [15:0] exp;
  } item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_reg_write;
  logic        wb_mem_to_reg;
  logic [15:0] wb_alu_result;
  logic [15:0] wb_read_data;
  logic [2:0]  wb_write_reg;
  logic [2:0]  rs_addr;
  logic [2:0]  rt_addr;
  logic [15:0] rs_data;
  logic [15:0] rt_data;
  logic [15:0] wb_data;
  logic        wb_valid;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [15:0] retire_count;

  item_t sb_q[$];
  int    checks   = 0;
  int    failures = 0;

  wb_regfile #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(3),
    .R0_ZERO   (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_reg_write (wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg),
    .wb_alu_result(wb_alu_result),
    .wb_read_data (wb_read_data),
    .wb_write_reg (wb_write_reg),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .wb_data      (wb_data),
    .wb_valid     (wb_valid),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  // Monitor: compare every queued expectation against the settled outputs
  always @(negedge clk) begin
    item_t       it;
    logic [15:0] act;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      case (it.sig)
        SigWbData:  act = wb_data;
        SigWbValid: act = {15'd0, wb_valid};
        SigRs:      act = rs_data;
        SigRt:      act = rt_data;
        SigDbg:     act = dbg_data;
        default:    act = retire_count;
      endcase
      checks++;
      if (act !== it.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h at %0t", it.name, act, it.exp, $time);
      end
    end
  end

  task automatic expect_val(input string name, input int sig, input logic [15:0] v);
    item_t it;
    it.name = name;
    it.sig  = sig;
    it.exp  = v;
    sb_q.push_back(it);
  endtask

  task automatic drive(input logic we, input logic m2r, input logic [15:0] alu,
                       input logic [15:0] rd, input logic [2:0] wr, input logic [2:0] rs,
                       input logic [2:0] rt, input logic [2:0] dbg);
    wb_reg_write  = we;
    wb_mem_to_reg = m2r;
    wb_alu_result = alu;
    wb_read_data  = rd;
    wb_write_reg  = wr;
    rs_addr       = rs;
    rt_addr       = rt;
    dbg_addr      = dbg;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, 3'd0);
    tick();
    rst = 1'b0;
    expect_val("count_after_first_reset", SigCount, 16'h0000);

    // Preload r1..r7 with 0x1111*index
    for (int i = 1; i < 8; i++) begin
      logic [15:0] v;
      v = 16'h1111 * i[15:0];
      drive(1'b1, 1'b0, v, 16'h0, i[2:0], 3'd0, 3'd0, 3'd0);
      tick();
    end

    // Reset cycle: storage still holds preloaded values until the edge
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, 3'd7);
    expect_val("preload_r7", SigDbg, 16'h7777);
    expect_val("preload_count", SigCount, 16'd7);
    tick();
    rst = 1'b0;

    for (int a = 0; a < 8; a++) begin
      drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, a[2:0]);
      expect_val($sformatf("reset_dbg_r%0d", a), SigDbg, 16'h0000);
      if (a == 0) expect_val("reset_count", SigCount, 16'h0000);
      tick();
    end

    // Mux and write: load data to r5, then ALU result to r6
    drive(1'b1, 1'b1, 16'hABCD, 16'h1234, 3'd5, 3'd5, 3'd1, 3'd5);
    expect_val("mux_load_wb_data", SigWbData, 16'h1234);
    expect_val("mux_load_wb_valid", SigWbValid, 16'h0001);
    expect_val("mux_load_rs_bypass", SigRs, 16'h1234);
    expect_val("mux_load_dbg_before", SigDbg, 16'h0000);
    tick();
    drive(1'b1, 1'b0, 16'hABCD, 16'h1234, 3'd6, 3'd1, 3'd1, 3'd5);
    expect_val("mux_alu_wb_data", SigWbData, 16'hABCD);
    expect_val("r5_committed", SigDbg, 16'h1234);
    expect_val("count_1", SigCount, 16'd1);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 3'd1, 3'd1, 3'd6);
    expect_val("r6_committed", SigDbg, 16'hABCD);
    expect_val("idle_wb_valid", SigWbValid, 16'h0000);
    expect_val("count_2", SigCount, 16'd2);
    tick();

    // Bypass on both ports while debug shows old value
    drive(1'b1, 1'b0, 16'h0001, 16'h0, 3'd3, 3'd1, 3'd1, 3'd3);
    tick();
    drive(1'b1, 1'b1, 16'h0, 16'hBEEF, 3'd3, 3'd3, 3'd3, 3'd3);
    expect_val("bypass_rs", SigRs, 16'hBEEF);
    expect_val("bypass_rt", SigRt, 16'hBEEF);
    expect_val("bypass_dbg_old", SigDbg, 16'h0001);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 3'd3, 3'd3, 3'd3);
    expect_val("r3_dbg_new", SigDbg, 16'hBEEF);
    expect_val("r3_rs_stored", SigRs, 16'hBEEF);
    expect_val("r3_rt_stored", SigRt, 16'hBEEF);
    expect_val("count_4", SigCount, 16'd4);
    tick();

    // r0 hardwired: write suppressed but counted
    drive(1'b1, 1'b1, 16'h0, 16'hFFFF, 3'd0, 3'd0, 3'd0, 3'd0);
    expect_val("r0_wb_valid", SigWbValid, 16'h0000);
    expect_val("r0_wb_data", SigWbData, 16'hFFFF);
    expect_val("r0_rs_same", SigRs, 16'h0000);
    expect_val("r0_rt_same", SigRt, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, 3'd0);
    expect_val("r0_rs_after", SigRs, 16'h0000);
    expect_val("r0_dbg_after", SigDbg, 16'h0000);
    expect_val("count_r0_write", SigCount, 16'd5);
    tick();

    // Bubble: r2 keeps its value, no bypass, no count
    drive(1'b1, 1'b0, 16'h0222, 16'h0, 3'd2, 3'd1, 3'd1, 3'd1);
    tick();
    drive(1'b0, 1'b1, 16'h0, 16'hDEAD, 3'd2, 3'd2, 3'd2, 3'd2);
    expect_val("bubble_wb_valid", SigWbValid, 16'h0000);
    expect_val("bubble_wb_data", SigWbData, 16'hDEAD);
    expect_val("bubble_rs_no_bypass", SigRs, 16'h0222);
    expect_val("bubble_rt_no_bypass", SigRt, 16'h0222);
    expect_val("count_6", SigCount, 16'd6);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 3'd1, 3'd1, 3'd2);
    expect_val("bubble_r2_kept", SigDbg, 16'h0222);
    expect_val("bubble_count_same", SigCount, 16'd6);
    tick();

    // Drive the count up to 0xFFFE with writes to r7
    for (int n = 0; n < 65528; n++) begin
      drive(1'b1, 1'b0, n[15:0], 16'h0, 3'd7, 3'd1, 3'd1, 3'd1);
      tick();
    end
    drive(1'b1, 1'b0, 16'h0, 16'h0, 3'd7, 3'd1, 3'd1, 3'd1);
    expect_val("count_fffe", SigCount, 16'hFFFE);
    tick();
    expect_val("sat_1", SigCount, 16'hFFFF);
    tick();
    expect_val("sat_2", SigCount, 16'hFFFF);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 3'd1, 3'd1, 3'd1);
    expect_val("sat_3", SigCount, 16'hFFFF);
    tick();

    // Reset overrides a simultaneous write; bypass stays live during reset
    rst = 1'b1;
    drive(1'b1, 1'b0, 16'h5555, 16'h0, 3'd4, 3'd4, 3'd1, 3'd4);
    expect_val("rst_wb_data", SigWbData, 16'h5555);
    expect_val("rst_wb_valid", SigWbValid, 16'h0001);
    expect_val("rst_rs_bypass", SigRs, 16'h5555);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 3'd4, 3'd3, 3'd4);
    expect_val("rst_r4_zero", SigDbg, 16'h0000);
    expect_val("rst_rs_r4_zero", SigRs, 16'h0000);
    expect_val("rst_rt_r3_zero", SigRt, 16'h0000);
    expect_val("rst_count_zero", SigCount, 16'h0000);
    tick();

    // First write after reset behaves normally
    drive(1'b1, 1'b0, 16'h0A0A, 16'h0, 3'd4, 3'd1, 3'd1, 3'd4);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 3'd1, 3'd1, 3'd4);
    expect_val("post_rst_r4", SigDbg, 16'h0A0A);
    expect_val("post_rst_count", SigCount, 16'd1);
    tick();

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
